// File: rtl/stack_cpu_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and default bus widths.
package stack_cpu_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick, purely combinational; a lone requester always wins,
// a tie goes to the port that did not win last time (last: 0 = port 0, 1 = port 1).
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] win
);

  assign win[0] = req0 & (~req1 | last);
  assign win[1] = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one shared memory: IDLE -> ACCESS x MEM_LAT -> RESP,
// so ack arrives MEM_LAT+1 cycles after the request; requesters wait by holding req until ack.
module mem_arbiter
  import stack_cpu_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  arb_state_t    r_state;
  logic [2:0]    r_cnt;
  logic          r_last;
  logic [1:0]    r_gnt;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_first;
  logic [1:0]    w_win;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (r_last),
    .win  (w_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_rdata <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_first <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win != 2'b00) begin
            r_gnt   <= w_win;
            r_last  <= w_win[1];
            r_adr   <= w_win[1] ? adr1 : adr0;
            r_wdata <= w_win[1] ? wdata1 : wdata0;
            r_we    <= w_win[1] ? we1 : we0;
            r_first <= 1'b1;
            r_cnt   <= 3'd0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 3'd1;
          // Read data is captured on the same edge that leaves ACCESS, so rdata is valid with ack.
          if (r_cnt == LAT_M1) begin
            r_rdata <= mem_rdata;
            r_ack0  <= r_gnt[0];
            r_ack1  <= r_gnt[1];
            r_state <= RESP;
          end
        end
        RESP: begin
          r_gnt   <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata     = r_rdata;
  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign mem_adr   = r_adr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_first & r_we;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 5, memory address width; DW, 8, memory data width; MEM_LAT, 1, read latency of the shared memory in cycles (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  access requests; port 0 is the CPU controller, port 1 is the DMA/debug requester.
REQ-005 we0, we1  input  1 each  write-enable qualifying each request.
REQ-006 adr0, adr1  input  AW each  request addresses.
REQ-007 wdata0, wdata1  input  DW each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulses.
REQ-009 rdata  output  DW  read data, valid while ack0 or ack1 is high.
REQ-010 gnt  output  2  one-hot grant (bit n for port n), held for the whole transaction.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 mem_adr  output  AW  shared memory address.
REQ-013 mem_wdata  output  DW  shared memory write data.
REQ-014 mem_we  output  1  shared memory write strobe.
REQ-015 mem_rdata  input  DW  shared memory read data, valid MEM_LAT cycles after mem_adr is presented.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-017 IDLE with no request SHALL remain in IDLE, with gnt=0 and mem_we=0.
REQ-018 IDLE with any request SHALL:
- select a winner per REQ-023;
- latch the winner's adr, we and wdata into internal registers;
- set gnt, clear the latency counter and move to ACCESS.
REQ-019 ACCESS SHALL drive mem_adr and mem_wdata from the latched registers.
REQ-020 mem_we SHALL be high only in the first ACCESS cycle, and only when the latched we=1.
REQ-021 ACCESS SHALL increment the 3-bit counter every cycle. When counter==MEM_LAT-1 it SHALL capture mem_rdata into the rdata register and move to RESP.
REQ-022 RESP SHALL:
- pulse the granted port's ack for exactly one cycle, with rdata valid;
- then return to IDLE, clearing gnt.
REQ-023 Arbitration SHALL be round-robin on a 1-bit last-granted pointer:
- a single requester always wins;
- on simultaneous requests, the port not granted last wins;
- the pointer updates on every grant.
REQ-024 Latency: a request first seen in IDLE at cycle T SHALL produce its ack at cycle T+MEM_LAT+1.
REQ-025 Back-to-back transactions SHALL be separated by one IDLE cycle, so peak throughput is one access per MEM_LAT+2 cycles.
REQ-026 Requests SHALL be sampled only in IDLE.
REQ-027 A requester SHALL hold req, we, adr and wdata stable until its ack.
REQ-028 If req deasserts mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-029 For writes, rdata on ack is don't-care but SHALL be the captured mem_rdata value.
REQ-030 A port whose req is still high in the IDLE cycle after its own ack SHALL be treated as a new request.
REQ-031 ack0 and ack1 SHALL never be high simultaneously. gnt SHALL always be 0 or one-hot.

Reset
REQ-032 While rst=0, outputs SHALL be forced asynchronously to:
- state=IDLE, gnt=0, ack0=ack1=0, busy=0, mem_we=0;
- mem_adr=0, mem_wdata=0, rdata=0;
- counter=0, last-granted pointer=1 (port 0 wins the first tie).
REQ-033 Reset asserted mid-transaction SHALL abort it: mem_we drops immediately and no ack is issued for the aborted request.
REQ-034 The first request after reset release SHALL be arbitrated normally in the first IDLE cycle.

Structure
REQ-035 The state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the AW/DW defaults SHALL live in the shared package stack_cpu_pkg.
REQ-036 The two-way round-robin selection (inputs req0, req1, last; outputs one-hot winner) SHALL be a separate sub-module rr_pick2.
REQ-037 The remaining logic (FSM, latency counter, latch registers) SHALL stay in mem_arbiter.

Verification
REQ-038 The bench SHALL cover the following directed scenarios (MEM_LAT=1 unless stated):
- Single read: req0=1, we0=0, adr0=5'd3 in IDLE, memory[3]=8'hA5 -> ack0 two cycles later with rdata=8'hA5; gnt=2'b01 throughout; ack1 stays 0.
- Write then read: req1 writes 8'h3C to adr 5'd17 -> mem_we high for one cycle and ack1 pulses; a following req1 read of 5'd17 -> rdata=8'h3C.
- Contention: req0 and req1 high together out of reset -> port 0 is granted first, then port 1; with both held continuously, the grants alternate 0,1,0,1.
- Latency: MEM_LAT=3, req0 read at cycle T -> ack0 at T+4; mem_we stays 0; busy is high for cycles T+1..T+4.
- Reset abort: rst pulled low during ACCESS of a port-1 write -> gnt=0, busy=0, mem_we=0 immediately and ack1 never pulses; after release, the pending req0 is granted in the first IDLE cycle.
- Early drop: req0 deasserted the cycle after its grant -> ack0 still pulses at the nominal cycle, and the FSM returns to IDLE.
